rca_4b: RTL and testbench
=========================

// Module: rca_4b
// PURPOSE
//  - 4-bit ripple-carry adder with registered outputs: {C_OUT,SUM} = X + Y + C_IN.
//  - Carry ripples bit-by-bit through a chain of single-bit full adders. The result is captured on the next rising CLK.
//  - Basic arithmetic leaf used wherever a small synchronous add with carry-in/carry-out is needed.
//  - Also serves as the building block for wider cascaded adders: C_OUT of one stage feeds C_IN of the next.
// PARAMETERS
//  - WIDTH  4  operand/sum width in bits. The adder must be correct for any WIDTH >= 1; 4 is the only configuration required.
// PORTS
//  - CLK    in   1      single clock; all state updates on its rising edge
//  - RST    in   1      reset, synchronous, active-high
//  - X      in   WIDTH  addend A, unsigned
//  - Y      in   WIDTH  addend B, unsigned
//  - C_IN   in   1      carry into bit 0
//  - SUM    out  WIDTH  registered sum bits [WIDTH-1:0]
//  - C_OUT  out  1      registered carry out of bit WIDTH-1
// BEHAVIOUR
//  - Combinational core:
//    - c[0] = C_IN.
//    - For each bit i: s[i] = X[i]^Y[i]^c[i]; c[i+1] = X[i]&Y[i] | c[i]&(X[i]^Y[i]).
//    - Carry out = c[WIDTH].
//  - Output register:
//    - On rising CLK with RST=1: SUM <= 0 and C_OUT <= 0, regardless of X/Y/C_IN.
//    - On rising CLK with RST=0: SUM <= s, C_OUT <= c[WIDTH].
//  - Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N and hold until edge N+1.
//  - Throughput: one new operation per cycle. No handshake and no valid signal; the block adds every cycle.
//  - Width rule: the result is modulo 2^WIDTH, with the overflow bit in C_OUT.
//    - X=Y=all-ones with C_IN=1 gives SUM=all-ones, C_OUT=1 (max result 2^(WIDTH+1)-1).
//  - Wrap-around: X=all-ones, Y=0, C_IN=1 propagates the carry through every stage, giving SUM=0, C_OUT=1.
//  - Reset mid-operation:
//    - RST has priority; the pending result is discarded.
//    - The first non-reset edge after RST deasserts loads the sum of the inputs present at that edge.
//  - Before the first reset, outputs are undefined (X in simulation).
//  - No latches. There is no combinational path from inputs to outputs.
// STRUCTURE
//  - Sub-module full_adder (ports A, B, CI, S, CO), instantiated WIDTH times via generate and chained through the carry.
//  - The output register lives in rca_4b.
//  - No shared package needed. A package constant for the default WIDTH (4) is acceptable if other adders reuse it.
// TESTING
//  - Each check below samples the outputs one cycle after applying the inputs.
//  - Reset: RST=1 for 2 cycles with X=1111, Y=1111, C_IN=1 -> SUM=0000, C_OUT=0 throughout.
//  - X=0000, Y=0000, C_IN=0 -> SUM=0000, C_OUT=0.
//  - Back-to-back operations, one per cycle (checks 1-cycle latency and throughput):
//    - X=0100, Y=1000, C_IN=0 -> next cycle SUM=1100, C_OUT=0.
//    - X=0011, Y=0111, C_IN=1 -> next cycle SUM=1011, C_OUT=0.
//    - X=1100, Y=0101, C_IN=0 -> next cycle SUM=0001, C_OUT=1.
//  - Full ripple: X=1111, Y=0000, C_IN=1 -> SUM=0000, C_OUT=1.
//  - Max result: X=1111, Y=1111, C_IN=1 -> SUM=1111, C_OUT=1.
//  - Mid-stream reset: assert RST during the X=0011, Y=0111, C_IN=1 cycle -> outputs 0000/0.
//    - Deassert RST -> the next operation's result appears one cycle later.
//  - Exhaustive self-check: all 512 combinations of X, Y, C_IN against a reference X+Y+C_IN, one cycle delayed.

Source files
------------

// File: rtl/rca_4b_pkg.sv
// Shared constants for the small ripple-carry adder family.
// Other adders built from the same leaf reuse the default width from here.
package rca_4b_pkg;

  localparam int RCA_WIDTH = 4;

endpackage : rca_4b_pkg

// File: rtl/rca_4b_if.sv
// Operand/result bundle for rca_4b: the master supplies operands and carry-in,
// the slave (the adder) returns the registered sum and carry-out.
interface rca_4b_if #(
  parameter int WIDTH = rca_4b_pkg::RCA_WIDTH
);

  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             C_IN;
  logic [WIDTH-1:0] SUM;
  logic             C_OUT;

  modport master (
    output X, Y, C_IN,
    input  SUM, C_OUT
  );

  modport slave (
    input  X, Y, C_IN,
    output SUM, C_OUT
  );

endinterface : rca_4b_if

// File: rtl/full_adder.sv
// Single-bit full adder; the rca_4b carry chain is a string of these.
module full_adder (
  input  logic A,
  input  logic B,
  input  logic CI,
  output logic S,
  output logic CO
);

  logic p;

  // Propagate term is shared between the sum and the carry-out.
  assign p  = A ^ B;
  assign S  = p ^ CI;
  assign CO = (A & B) | (CI & p);

endmodule : full_adder

// File: rtl/rca_4b.sv
// Ripple-carry adder with registered outputs: {C_OUT,SUM} = X + Y + C_IN,
// one result per cycle, one cycle of latency.
module rca_4b
  import rca_4b_pkg::*;
#(
  parameter int WIDTH = RCA_WIDTH
) (
  input  logic    CLK,
  input  logic    RST,
  rca_4b_if.slave bus
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;

  assign c[0] = bus.C_IN;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .A  (bus.X[i]),
      .B  (bus.Y[i]),
      .CI (c[i]),
      .S  (s[i]),
      .CO (c[i+1])
    );
  end

  // Reset is synchronous and wins over any pending result; outputs stay
  // unknown until the first reset edge.
  always_ff @(posedge CLK) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (RST) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= s;
      c_out_q <= c[WIDTH];
    end
  end

  assign bus.SUM   = sum_q;
  assign bus.C_OUT = c_out_q;

endmodule : rca_4b

// File: tb/tb_rca_4b.sv
// Directed and exhaustive checks of rca_4b against hand-computed and
// reference X+Y+C_IN results, each sampled one cycle after the inputs.
module tb_rca_4b;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  rca_4b_if #(.WIDTH(4)) bus ();

  rca_4b #(.WIDTH(4)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got {c_out,sum}=%b_%b expected %b_%b",
               tag, got[4], got[3:0], exp[4], exp[3:0]);
    end
  endtask

  // Apply one set of inputs, clock once, then sample 1 time unit after the edge.
  task automatic step(input logic r, input logic [3:0] x, input logic [3:0] y,
                      input logic ci, input logic [4:0] exp, input string tag);
    rst      = r;
    bus.X    = x;
    bus.Y    = y;
    bus.C_IN = ci;
    @(posedge clk);
    #1;
    check(tag, {bus.C_OUT, bus.SUM}, exp);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    bus.X    = 4'b0000;
    bus.Y    = 4'b0000;
    bus.C_IN = 1'b0;
    #2;

    // Reset held two cycles with operands that would otherwise give 1_1111.
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 5'b0_0000, "reset_cycle0");
    step(1'b1, 4'b1111, 4'b1111, 1'b1, 5'b0_0000, "reset_cycle1");

    step(1'b0, 4'b0000, 4'b0000, 1'b0, 5'b0_0000, "zero");

    // Back-to-back, one operation per cycle.
    step(1'b0, 4'b0100, 4'b1000, 1'b0, 5'b0_1100, "b2b_4p8");
    step(1'b0, 4'b0011, 4'b0111, 1'b1, 5'b0_1011, "b2b_3p7p1");
    step(1'b0, 4'b1100, 4'b0101, 1'b0, 5'b1_0001, "b2b_12p5");

    step(1'b0, 4'b1111, 4'b0000, 1'b1, 5'b1_0000, "full_ripple");
    step(1'b0, 4'b1111, 4'b1111, 1'b1, 5'b1_1111, "max_result");

    // Mid-stream reset discards the pending result; next op lands one cycle later.
    step(1'b0, 4'b0100, 4'b1000, 1'b0, 5'b0_1100, "pre_reset_op");
    step(1'b1, 4'b0011, 4'b0111, 1'b1, 5'b0_0000, "mid_reset");
    step(1'b0, 4'b1100, 4'b0101, 1'b0, 5'b1_0001, "post_reset_op");
    step(1'b0, 4'b0001, 4'b0010, 1'b1, 5'b0_0100, "post_reset_op2");

    // Exhaustive sweep against the arithmetic reference.
    for (int i = 0; i < 512; i++) begin
      logic [3:0] xv;
      logic [3:0] yv;
      logic       cv;
      logic [4:0] ref_sum;
      xv      = 4'(i);
      yv      = 4'(i >> 4);
      cv      = 1'(i >> 8);
      ref_sum = 5'(xv) + 5'(yv) + 5'(cv);
      step(1'b0, xv, yv, cv, ref_sum, $sformatf("exh_x%0h_y%0h_c%0d", xv, yv, cv));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_rca_4b
